led_cube_frame_buffer: RTL
==========================

# led_cube_frame_buffer

Assembles framed byte streams from the UART front end into a double-buffered 8×8×8 LED cube image and serves it to the layer-scan driver. Sits directly downstream of the UART poller: consumes its received byte and one-cycle valid strobe, parses sync/mode/payload, and swaps the completed image in only at a scan-frame boundary so the cube never shows a torn frame.

## Interface
Parameters:
- SYNC_BYTE, 8'hA5, frame start marker
- TIMEOUT_CYCLES, 1_000_000, max clocks between bytes inside a frame before abort

Ports:
- clock_sink_clk  in  1  system clock; all logic on rising edge
- reset_sink_reset  in  1  reset, asynchronous, active-high
- byte_in  in  8  received UART byte
- byte_valid  in  1  one-cycle strobe, byte_in valid this cycle
- scan_frame_end  in  1  one-cycle pulse from scanner after the last layer of a refresh
- rd_layer  in  3  scanner read address, layer 0–7
- rd_row  in  3  scanner read address, row 0–7
- rd_data  out  8  front-buffer byte at {rd_layer, rd_row}, bit j = column j
- mode  out  4  mode nibble of the currently displayed frame
- frame_count  out  8  frames swapped in, wraps 255→0
- overrun_count  out  8  bytes dropped while a swap is pending, saturates at 255
- timeout_count  out  8  frames aborted by timeout, saturates at 255
- busy  out  1  high while the parser is in MODE, DATA or WAIT_SWAP

## Operation
- Frame format: SYNC_BYTE, MODE byte (bits [3:0] used, [7:4] ignored), 64 payload bytes; payload index k = layer*8 + row.
- Parser states: IDLE, MODE, DATA, WAIT_SWAP.
  - IDLE: byte_valid with byte_in == SYNC_BYTE → MODE; other bytes discarded silently.
  - MODE: byte_valid → latch pending_mode = byte_in[3:0], clear byte index to 0 → DATA.
  - DATA: each byte_valid writes byte_in to back buffer at index, index increments; write of index 63 → WAIT_SWAP. SYNC_BYTE in payload is ordinary data, no resync.
  - WAIT_SWAP: byte_valid → byte dropped, overrun_count increments (saturating). On scan_frame_end → buffer select toggles, mode ← pending_mode, frame_count increments, → IDLE.
- Timeout: in MODE or DATA, an idle-cycle counter clears on each byte_valid and increments otherwise; reaching TIMEOUT_CYCLES → IDLE, timeout_count increments, partial frame discarded, front buffer and mode unchanged. No timeout in IDLE or WAIT_SWAP.
- Reads always come from the front buffer; writes always go to the back buffer.

## Timing
- rd_data registered: address applied in cycle N → data valid in cycle N+1. Swap takes effect for reads addressed the cycle after the swap edge.
- Payload byte accepted in the cycle its byte_valid is high; byte 63 write and entry to WAIT_SWAP on the same edge.
- scan_frame_end in the same cycle as the byte-63 write is ignored; swap waits for the next scan_frame_end.
- byte_valid and scan_frame_end together in WAIT_SWAP: swap happens, byte counted as overrun and dropped (no SYNC detection that cycle).
- Timeout and byte_valid in the same cycle: byte wins, counter clears.
- Reset (async assert, any state): state IDLE, buffer select 0, rd_data 0, mode 0, all counts 0, busy 0; partial frame lost. RAM contents not reset — undefined until first swap.
- Back-to-back byte_valid every cycle supported; minimum frame time 66 cycles plus swap wait.

## Structure
- Shared package led_cube_pkg: SYNC_BYTE default, FRAME_BYTES = 64, parser state enum.
- Sub-module led_cube_frame_ram: 128×8 simple dual-port RAM (one write port, one registered read port), bank bit = MSB of address; top maps back/front bank from buffer select.
- Timeout counter width $clog2(TIMEOUT_CYCLES+1).

## Test plan
- Valid frame A5, 03, bytes k=0..63 value k, then scan_frame_end → frame_count 1, mode 3, read layer 2 row 5 gives 8'h15 one cycle later.
- Junk 11, 22 before A5 then valid frame → junk ignored, frame stored identically, overrun_count 0.
- Second frame completes, 5 extra bytes before scan_frame_end → overrun_count 5, old image readable until swap, new image after.
- Frame stops after 10 payload bytes, idle TIMEOUT_CYCLES (set to 100) → timeout_count 1, state IDLE, mode and displayed image unchanged.
- Payload containing A5 at k=7 → stored as data, frame completes normally with 64 bytes.
- Reset asserted mid-DATA → busy 0, all counts 0, mode 0 immediately; following full frame accepted and swapped to bank 1.

Source files
------------

// File: rtl/led_cube_pkg.sv
// Shared definitions for the LED cube frame buffer: sync marker, frame size, parser states.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package led_cube_pkg;

    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
    localparam int         FRAME_BYTES   = 64;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_MODE      = 2'd1,
        ST_DATA      = 2'd2,
        ST_WAIT_SWAP = 2'd3
    } parser_state_t;

endpackage

// File: rtl/led_cube_frame_ram.sv
// 128x8 simple dual-port image RAM: one write port, one registered read port; addr[6] selects the bank.
// Latency: write lands on the clock edge; read data appears one cycle after its address.
// Backpressure: none; both ports accept every cycle.
// Ports: clk/rst, we/waddr/wdata (write), raddr -> rdata (registered read, cleared by reset).
module led_cube_frame_ram (
    input  logic       clk,
    input  logic       rst,
    input  logic       we,
    input  logic [6:0] waddr,
    input  logic [7:0] wdata,
    input  logic [6:0] raddr,
    output logic [7:0] rdata
);

    logic [7:0] mem [0:127];

    // Storage is deliberately not reset; contents are only meaningful once a frame has been swapped in.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= 8'h00;
        end else begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/led_cube_frame_buffer.sv
// Parses SYNC/MODE/64-byte frames from the UART into a back buffer and swaps it to the front at scan-frame end.
// Latency: rd_data one cycle after {rd_layer, rd_row}; a completed frame shows after the next scan_frame_end.
// Backpressure: none upstream; bytes arriving while a swap is pending are dropped and counted in overrun_count.
// Ports: clock_sink_clk/reset_sink_reset; byte_in/byte_valid (UART); scan_frame_end, rd_layer, rd_row -> rd_data (scanner);
//        mode, frame_count, overrun_count, timeout_count, busy (status).
module led_cube_frame_buffer
    import led_cube_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEF,
    parameter int         TIMEOUT_CYCLES = 1_000_000
) (
    input  logic       clock_sink_clk,
    input  logic       reset_sink_reset,
    input  logic [7:0] byte_in,
    input  logic       byte_valid,
    input  logic       scan_frame_end,
    input  logic [2:0] rd_layer,
    input  logic [2:0] rd_row,
    output logic [7:0] rd_data,
    output logic [3:0] mode,
    output logic [7:0] frame_count,
    output logic [7:0] overrun_count,
    output logic [7:0] timeout_count,
    output logic       busy
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    parser_state_t state, state_nxt;

    logic          buf_sel;       // bank currently shown to the scanner
    logic [5:0]    idx;           // next payload index, layer*8 + row
    logic [3:0]    pending_mode;
    logic [TW-1:0] idle_cnt;

    logic ram_we;
    logic latch_mode;
    logic do_swap;
    logic ovr_inc;
    logic to_inc;
    logic timed_out;

    // This cycle would be the TIMEOUT_CYCLES-th consecutive one without a byte.
    assign timed_out = (idle_cnt == TW'(TIMEOUT_CYCLES - 1)) && !byte_valid;

    always_ff @(posedge clock_sink_clk or posedge reset_sink_reset) begin
        if (reset_sink_reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        ram_we     = 1'b0;
        latch_mode = 1'b0;
        do_swap    = 1'b0;
        ovr_inc    = 1'b0;
        to_inc     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (byte_valid && (byte_in == SYNC_BYTE)) begin
                    state_nxt = ST_MODE;
                end
            end
            ST_MODE: begin
                if (byte_valid) begin
                    latch_mode = 1'b1;
                    state_nxt  = ST_DATA;
                end else if (timed_out) begin
                    to_inc    = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            ST_DATA: begin
                // Payload is taken verbatim: a SYNC value here is just pixel data.
                if (byte_valid) begin
                    ram_we = 1'b1;
                    if (idx == 6'(FRAME_BYTES - 1)) begin
                        state_nxt = ST_WAIT_SWAP;
                    end
                end else if (timed_out) begin
                    to_inc    = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            ST_WAIT_SWAP: begin
                // A byte arriving here is always dropped, even alongside the swap.
                ovr_inc = byte_valid;
                if (scan_frame_end) begin
                    do_swap   = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock_sink_clk or posedge reset_sink_reset) begin
        if (reset_sink_reset) begin
            buf_sel       <= 1'b0;
            idx           <= 6'd0;
            pending_mode  <= 4'd0;
            mode          <= 4'd0;
            idle_cnt      <= '0;
            frame_count   <= 8'd0;
            overrun_count <= 8'd0;
            timeout_count <= 8'd0;
        end else begin
            if (latch_mode) begin
                pending_mode <= byte_in[3:0];
                idx          <= 6'd0;
            end else if (ram_we) begin
                idx <= idx + 6'd1;
            end

            if (byte_valid || to_inc || !((state == ST_MODE) || (state == ST_DATA))) begin
                idle_cnt <= '0;
            end else begin
                idle_cnt <= idle_cnt + TW'(1);
            end

            if (do_swap) begin
                buf_sel     <= ~buf_sel;
                mode        <= pending_mode;
                frame_count <= frame_count + 8'd1;
            end

            if (ovr_inc && (overrun_count != 8'hFF)) begin
                overrun_count <= overrun_count + 8'd1;
            end

            if (to_inc && (timeout_count != 8'hFF)) begin
                timeout_count <= timeout_count + 8'd1;
            end
        end
    end

    assign busy = (state != ST_IDLE);

    // Writes target the hidden bank, reads the shown one; the swap edge flips both at once.
    led_cube_frame_ram u_ram (
        .clk   (clock_sink_clk),
        .rst   (reset_sink_reset),
        .we    (ram_we),
        .waddr ({~buf_sel, idx}),
        .wdata (byte_in),
        .raddr ({buf_sel, rd_layer, rd_row}),
        .rdata (rd_data)
    );

endmodule
